store_buffer: RTL

- Posted-write buffer between the core's load/store path and the single-ported data memory (`we`, `a`, `wd` in; `rd` out).
- Core stores are queued and retired to memory one per cycle, in the cycles when no load is using the shared memory address port.
- Loads are checked against queued stores, and the youngest matching word is forwarded.
- Raises back-pressure to the core when full.

---
 rtl/sb_pkg.sv | 11 +
 rtl/sb_fwd_match.sv | 27 ++
 rtl/store_buffer.sv | 77 +++++++
 3 files changed

// File: rtl/sb_pkg.sv
// sb_pkg: shared constants and types for the store buffer
package sb_pkg;
    localparam int SB_N = 32;
    localparam int SB_DEPTH = 4;
    localparam int SB_PTR_W = $clog2(SB_DEPTH);
    localparam int WORD_LSB = 2;
    typedef struct packed {
        logic [SB_N-1:0] addr;
        logic [SB_N-1:0] data;
    } sb_entry_t;
endpackage

// File: rtl/sb_fwd_match.sv
// sb_fwd_match: age-ordered word-address match over occupied entries, youngest wins
module sb_fwd_match import sb_pkg::*; #(
    parameter int n = SB_N,
    parameter int DEPTH = SB_DEPTH,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic [n-1:WORD_LSB] ent_waddr [DEPTH],
    input  logic [n-1:0]        ent_data [DEPTH],
    input  logic [PW-1:0]       head,
    input  logic [CW-1:0]       count,
    input  logic [n-1:WORD_LSB] ld_waddr,
    output logic                hit,
    output logic [n-1:0]        data
);
    // walk oldest to youngest so a later match overrides an earlier one
    always_comb begin
        hit = 1'b0;
        data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < count && ent_waddr[head + PW'(k)] == ld_waddr) begin
                hit = 1'b1;
                data = ent_data[head + PW'(k)];
            end
        end
    end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO in front of the data memory with youngest-match load forwarding
module store_buffer import sb_pkg::*; #(
    parameter int n = SB_N,
    parameter int DEPTH = SB_DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         st_valid,
    input  logic [n-1:0] st_addr,
    input  logic [n-1:0] st_wdata,
    output logic         st_ready,
    input  logic         ld_valid,
    input  logic [n-1:0] ld_addr,
    output logic         ld_hit,
    output logic [n-1:0] ld_fwd_data,
    output logic         mem_we,
    output logic [n-1:0] mem_addr,
    output logic [n-1:0] mem_wd,
    output logic         sb_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [n-1:0]        addr_q [DEPTH];
    logic [n-1:0]        data_q [DEPTH];
    logic [n-1:WORD_LSB] waddr [DEPTH];
    logic [PW-1:0]       head_q, tail_q;
    logic [CW-1:0]       count_q;
    logic                enq, drain, hit;
    logic [n-1:0]        fwd;

    assign st_ready = count_q != CW'(DEPTH);
    assign sb_empty = count_q == '0;
    assign enq = st_valid && st_ready;
    // loads always own the memory port; stores retire only in idle cycles
    assign drain = !sb_empty && !ld_valid;

    for (genvar i = 0; i < DEPTH; i++) begin : g_waddr
        assign waddr[i] = addr_q[i][n-1:WORD_LSB];
    end

    sb_fwd_match #(.n(n), .DEPTH(DEPTH)) u_match (
        .ent_waddr(waddr),
        .ent_data(data_q),
        .head(head_q),
        .count(count_q),
        .ld_waddr(ld_addr[n-1:WORD_LSB]),
        .hit(hit),
        .data(fwd)
    );

    always_comb begin
        mem_we = drain;
        mem_addr = drain ? addr_q[head_q] : ld_valid ? ld_addr : '0;
        mem_wd = drain ? data_q[head_q] : '0;
        ld_hit = ld_valid && hit;
        ld_fwd_data = ld_hit ? fwd : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            count_q <= '0;
        end else begin
            if (enq) tail_q <= tail_q + PW'(1);
            if (drain) head_q <= head_q + PW'(1);
            count_q <= count_q + CW'(enq) - CW'(drain);
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail_q] <= st_addr;
            data_q[tail_q] <= st_wdata;
        end
    end
endmodule
